// File: rtl/moving_average.sv
// -----------------------------------------------------------------------------
// moving_average
//
// Streaming signed moving-average filter over the last TAPS = 2^LOG2_TAPS
// accepted samples. It sits directly downstream of the pipeline data register
// and produces a registered, valid-flagged window average for the next stage.
//
// Parameters
//   DATA_WIDTH : sample and output width, two's-complement signed
//   LOG2_TAPS  : log2 of the window length, legal range 1..6
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   reset     : asynchronous, active-low reset
//   valid_i   : data_i holds a sample to accept this cycle
//   data_i    : signed input sample
//   clear_i   : synchronous flush of buffer, sum and fill count
//   valid_o   : one-cycle pulse, data_o holds a new average
//   data_o    : signed window average, registered
//   primed_o  : high once TAPS samples have been accepted since reset/clear
//
// Handshake: valid_i has no ready counterpart. A sample is taken on every
// rising edge where valid_i=1 and clear_i=0; valid_o pulses on the following
// edge for exactly one cycle. There is no backpressure and no stall.
//
// Build option
//   ROUND_EN : when defined, the average rounds half toward +inf instead of
//              flooring toward -inf. Timing is identical in both builds.
// -----------------------------------------------------------------------------
module moving_average #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG2_TAPS  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  clear_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  primed_o
);

  localparam int TAPS  = 1 << LOG2_TAPS;
  // The sum of TAPS signed DATA_WIDTH values always fits in this width.
  localparam int SUM_W = DATA_WIDTH + LOG2_TAPS;
  localparam logic [LOG2_TAPS:0] FILL_FULL = (LOG2_TAPS + 1)'(TAPS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]   buf_q [TAPS];
  logic [LOG2_TAPS-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LOG2_TAPS:0]      fill_q, fill_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    primed_q, primed_d;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic                    accept;
  logic [DATA_WIDTH-1:0]   oldest;
  logic signed [SUM_W-1:0] new_ext;
  logic signed [SUM_W-1:0] old_ext;
  logic signed [SUM_W-1:0] sum_next;
  logic [DATA_WIDTH-1:0]   avg;

  // Clear wins over a simultaneous valid sample; that sample is dropped.
  assign accept = valid_i & ~clear_i;

  // Entry about to be overwritten is the oldest sample in the window. Entries
  // not yet written hold 0, which gives the scaled-down warm-up outputs.
  assign oldest  = buf_q[wr_ptr_q];
  assign new_ext = {{LOG2_TAPS{data_i[DATA_WIDTH-1]}}, data_i};
  assign old_ext = {{LOG2_TAPS{oldest[DATA_WIDTH-1]}}, oldest};

  assign sum_next = sum_q + new_ext - old_ext;

`ifdef ROUND_EN
  // One bit wider than the accumulator so adding the half-LSB cannot wrap.
  logic signed [SUM_W:0] sum_round;
  logic                  unused_round_bits;

  assign sum_round = {sum_next[SUM_W-1], sum_next}
                   + (SUM_W + 1)'(1 << (LOG2_TAPS - 1));
  // Bits [SUM_W-1:LOG2_TAPS] are the arithmetic shift truncated to DATA_WIDTH.
  assign avg = sum_round[SUM_W-1:LOG2_TAPS];
  // The top bit is only a sign guard and the low bits are the shifted-out
  // fraction; neither reaches the output.
  assign unused_round_bits = ^{sum_round[SUM_W], sum_round[LOG2_TAPS-1:0]};
`else
  // Selecting bits above LOG2_TAPS is exactly sum_next >>> LOG2_TAPS
  // (floor toward -inf) truncated to DATA_WIDTH; the result is always in range.
  assign avg = sum_next[SUM_W-1:LOG2_TAPS];
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    sum_d    = sum_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    primed_d = primed_q;

    if (clear_i) begin
      wr_ptr_d = '0;
      fill_d   = '0;
      sum_d    = '0;
      primed_d = 1'b0;
    end else if (valid_i) begin
      // Pointer width is LOG2_TAPS, so TAPS-1 wraps to 0 naturally.
      wr_ptr_d = wr_ptr_q + LOG2_TAPS'(1);
      sum_d    = sum_next;
      data_d   = avg;
      valid_d  = 1'b1;
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + (LOG2_TAPS + 1)'(1);
      end
      // Rises on the same edge that writes the TAPS-th sample.
      if (fill_d == FILL_FULL) begin
        primed_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample buffer: a register array so that clear empties it in one cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) begin
        buf_q[i] <= '0;
      end
    end else if (clear_i) begin
      for (int i = 0; i < TAPS; i++) begin
        buf_q[i] <= '0;
      end
    end else if (accept) begin
      buf_q[wr_ptr_q] <= data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      sum_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      sum_q    <= sum_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      primed_q <= primed_d;
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign primed_o = primed_q;

endmodule

// File: doc/moving_average.md
Name: moving_average

Overview:
- Streaming signed moving-average filter over the last 2^LOG2_TAPS accepted samples.
- Sits directly downstream of the pipeline data register and consumes its registered sample output.
- Adds a valid qualifier, a circular sample buffer, a running-sum accumulator and a registered, valid-flagged average output for the next processing stage.

Parameters:
DATA_WIDTH, 32, sample and output width, two's-complement signed
LOG2_TAPS, 3, log2 of window length; TAPS = 2^LOG2_TAPS; legal range 1..6

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
valid_i  input  1  data_i holds a sample to accept this cycle
data_i  input  DATA_WIDTH  signed input sample
clear_i  input  1  synchronous flush of buffer, sum and fill count
valid_o  output  1  one-cycle pulse; data_o holds a new average
data_o  output  DATA_WIDTH  signed window average, registered
primed_o  output  1  high once TAPS samples accepted since reset/clear

Behaviour:
- Reset (reset=0, async): buffer entries, write pointer, fill count, accumulator, data_o, valid_o and primed_o all clear to 0.
- Buffer: TAPS x DATA_WIDTH register array (not RAM), so clear takes one cycle. Write pointer wraps TAPS-1 -> 0.
- Accumulator: signed, DATA_WIDTH+LOG2_TAPS bits; it cannot overflow.
- Accept (valid_i=1, clear_i=0):
  - sum_next = sum + sext(data_i) - sext(buf[wr_ptr]).
  - buf[wr_ptr] <= data_i; wr_ptr increments; sum <= sum_next.
- Output:
  - Next edge after accept: data_o = sum_next >>> LOG2_TAPS (arithmetic shift, floor toward -inf), truncated to DATA_WIDTH. No clipping is needed, because the result is always in range.
  - valid_o = 1 for exactly that cycle. Latency: valid_i edge -> valid_o 1 cycle.
- Idle (valid_i=0):
  - No state change; valid_o = 0; data_o holds its last value.
  - data_i is ignored.
- Warm-up:
  - Unfilled entries count as 0, so early outputs are scaled down (e.g. the first output is data_i/TAPS).
  - Fill counter saturates at TAPS; primed_o goes high on the same edge that writes the TAPS-th sample and stays high until reset or clear.
- Back-to-back valid_i every cycle: one output per input, no stalls, no backpressure.
- Clear (clear_i=1):
  - Next edge: buffer, sum, wr_ptr, fill count and primed_o go to 0; valid_o = 0; data_o holds.
  - Clear beats valid_i in the same cycle; that sample is dropped.
- Reset mid-stream: immediate async clear; the first output after release follows warm-up rules.

Optional Feature:
ROUND_EN
- Defined: data_o = (sum_next + 2^(LOG2_TAPS-1)) >>> LOG2_TAPS, i.e. round half toward +inf. The adder is one bit wider than the accumulator, so no overflow.
- Undefined: plain arithmetic shift (floor).
- Latency, valid timing and all other behaviour are identical in both builds.

Test Plan:
- DATA_WIDTH=16, LOG2_TAPS=2; after reset, data_i=8 with valid_i=1 for 6 cycles -> data_o 2,4,6,8,8,8 on consecutive cycles; valid_o high 6 cycles, one cycle after valid_i; primed_o rises with the 4th output.
- Samples 1,2,3,4,5 back-to-back -> outputs 0,0,1,2,3 (sums 1,3,6,10,14 → oldest sample 1 evicted at 5th).
- Single sample 6 then valid_i=0 for 3 cycles with data_i toggling -> data_o=1 (ROUND_EN: 2), then holds; valid_o single pulse. Single sample -3 -> -1 in both builds.
- DATA_WIDTH=8: four samples 127 -> final output 127; then four samples -128 -> final output -128; no wrap or overflow.
- After 4 samples of 8 (output 8), assert clear_i with valid_i=1, data_i=100 -> no valid_o, primed_o=0; next sample 4 -> output 1.
- Drop reset low mid-stream for half a cycle -> data_o=0, valid_o=0, primed_o=0 immediately; after release, sample 12 -> output 3.
